// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control decode slice.
//   - opcode / funct constants used by the decoder
//   - ctrl_t: every field the decoder produces for one instruction; the
//     ALU operation is carried as the raw 4-bit funct/opcode slice and is
//     resized to the pipeline's ALUOP_W at the output.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] FUNCT_JR = 6'd8;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [3:0]  aluop;
    logic        ir;
    logic [15:0] i_data;
    logic [25:0] jump_address;
    logic        we_reg;
    logic        we_mem;
    logic        mem_rd;
    logic        load_enable;
    logic        j_enable;
    logic        ra_enable;
    logic        branch_i;
    logic        branch_it;
    logic        is_lui;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_comb.sv
// Pure combinational MIPS control decode: instr -> ctrl_t.
// Ports:
//   instr   in   32  instruction word
//   ctrl    out  ctrl_t decoded control fields
//   use_rs  out  1   instruction reads the rs register
//   use_rt  out  1   instruction reads the rt register
module mips_decode_comb
  import mips_ctrl_pkg::*;
#(
  parameter int LINK_REG = 31
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        use_rs,
  output logic        use_rt
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    // NOTE: every output gets a default before the case so each path
    // assigns every bit and no latch is inferred.
    ctrl              = '0;
    ctrl.rs           = instr[25:21];
    ctrl.rt           = instr[20:16];
    ctrl.shamt        = instr[10:6];
    ctrl.i_data       = instr[15:0];
    ctrl.jump_address = instr[25:0];
    use_rs            = 1'b1;
    use_rt            = 1'b0;

    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          ctrl.load_enable = 1'b1;
        end else begin
          ctrl.rd     = instr[15:11];
          ctrl.aluop  = funct[3:0];
          ctrl.we_reg = 1'b1;
          use_rt      = 1'b1;
        end
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch_it = 1'b1;
        ctrl.aluop     = 4'd2;
        ctrl.branch_i  = instr[26];
        use_rt         = 1'b1;
      end
      OP_J, OP_JAL: begin
        ctrl.load_enable = 1'b1;
        ctrl.j_enable    = 1'b1;
        use_rs           = 1'b0;
        if (op == OP_JAL) begin
          ctrl.we_reg    = 1'b1;
          ctrl.ra_enable = 1'b1;
          ctrl.rd        = 5'(LINK_REG);
        end
      end
      OP_LUI: begin
        ctrl.rd     = instr[20:16];
        ctrl.shamt  = 5'd16;
        ctrl.is_lui = 1'b1;
        ctrl.we_reg = 1'b1;
        use_rs      = 1'b0;
      end
      default: begin
        ctrl.rd = instr[20:16];
        ctrl.ir = 1'b1;
        if (op[5]) begin
          // Load/store: instr[29] separates stores from loads.
          ctrl.we_mem = instr[29];
          ctrl.we_reg = ~instr[29];
          ctrl.mem_rd = ~instr[29];
          use_rt      = instr[29];
        end else begin
          ctrl.aluop  = op[3:0];
          ctrl.we_reg = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered MIPS control decoder between fetch and execute.
// Decodes one instruction per cycle into a pipeline register with
// valid/ready handshakes, a load-use interlock that issues bubbles,
// a synchronous branch/jump flush and output back-pressure.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr, in_valid, in_ready  fetch-side handshake
//   flush                      cancel the in-flight decode
//   out_ready, out_valid       execute-side handshake
//   rs_add..is_lui             registered decoded fields
//   stall                      a load-use bubble is being issued
module decode_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int STALL_CYCLES = 1,
  parameter int HAZARD_EN    = 1,
  parameter int LINK_REG     = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [4:0]         rs_add,
  output logic [4:0]         rt_add,
  output logic [4:0]         rd_add,
  output logic [4:0]         shamt,
  output logic [ALUOP_W-1:0] aluop,
  output logic               IR,
  output logic [15:0]        I_data,
  output logic [25:0]        jump_address,
  output logic               WE_reg,
  output logic               WE_mem,
  output logic               mem_rd,
  output logic               load_enable,
  output logic               j_enable,
  output logic               ra_enable,
  output logic               branch_i,
  output logic               BRANCH_IT,
  output logic               is_lui,
  output logic               stall
);

  localparam logic [1:0] STALL_LOAD = 2'(STALL_CYCLES);

  ctrl_t      dec;
  ctrl_t      q;
  logic       use_rs;
  logic       use_rt;
  logic       valid_q;
  logic       stall_q;
  logic       ready_en;   // holds in_ready low until the first edge after reset
  logic       ld_pend;
  logic [4:0] ld_rd;
  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic       hazard;
  logic       advance;
  logic       stall_pending;
  logic       accept;

  mips_decode_comb #(.LINK_REG(LINK_REG)) u_decode (
    .instr  (instr),
    .ctrl   (dec),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  // Register 0 is never a hazard source: ld_rd == 0 masks the compare.
  assign hazard = (HAZARD_EN != 0) && in_valid && ld_pend && (ld_rd != 5'd0) &&
                  ((use_rs && (dec.rs == ld_rd)) || (use_rt && (dec.rt == ld_rd)));

  assign advance       = ~valid_q | out_ready;
  assign stall_pending = hazard | (cnt != 2'd0);
  assign in_ready      = ready_en & (flush | (advance & ~stall_pending));
  assign accept        = in_valid & in_ready & ~flush;

  // A fresh hazard starts the count at STALL_CYCLES; the bubble issued on
  // the same edge already consumes one of them.
  assign cnt_next = ((cnt != 2'd0) ? cnt : STALL_LOAD) - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      q        <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      ready_en <= 1'b0;
      ld_pend  <= 1'b0;
      ld_rd    <= 5'd0;
      cnt      <= 2'd0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        q       <= '0;
        valid_q <= 1'b0;
        stall_q <= 1'b0;
        ld_pend <= 1'b0;
        cnt     <= 2'd0;
      end else if (advance) begin
        if (stall_pending) begin
          q       <= '0;
          valid_q <= 1'b0;
          stall_q <= 1'b1;
          cnt     <= cnt_next;
          if (cnt_next == 2'd0) ld_pend <= 1'b0;
        end else if (accept) begin
          q       <= dec;
          valid_q <= 1'b1;
          stall_q <= 1'b0;
          ld_pend <= dec.mem_rd;
          ld_rd   <= dec.rd;
        end else begin
          q       <= '0;
          valid_q <= 1'b0;
          stall_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid    = valid_q;
  assign stall        = stall_q;
  assign rs_add       = q.rs;
  assign rt_add       = q.rt;
  assign rd_add       = q.rd;
  assign shamt        = q.shamt;
  assign aluop        = ALUOP_W'(q.aluop);
  assign IR           = q.ir;
  assign I_data       = q.i_data;
  assign jump_address = q.jump_address;
  assign WE_reg       = q.we_reg;
  assign WE_mem       = q.we_mem;
  assign mem_rd       = q.mem_rd;
  assign load_enable  = q.load_enable;
  assign j_enable     = q.j_enable;
  assign ra_enable    = q.ra_enable;
  assign branch_i     = q.branch_i;
  assign BRANCH_IT    = q.branch_it;
  assign is_lui       = q.is_lui;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe. Two instances share stimulus:
// instance 0 with one bubble per load-use hazard, instance 1 with two.
// A transaction-level model predicts every output each cycle.
module tb_decode_ctrl_pipe;

  localparam logic [31:0] ADD   = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] LW5   = 32'h8C250000; // lw  $5,0($1)
  localparam logic [31:0] ADD2  = 32'h00A23020; // add $6,$5,$2
  localparam logic [31:0] LW0   = 32'h8C200000; // lw  $0,0($1)
  localparam logic [31:0] ADD00 = 32'h00003020; // add $6,$0,$0
  localparam logic [31:0] SW7   = 32'hAC270000; // sw  $7,0($1)
  localparam logic [31:0] SW5   = 32'hAC250000; // sw  $5,0($1)
  localparam logic [31:0] ADDI  = 32'h20240005; // addi $4,$1,5
  localparam logic [31:0] JAL   = 32'h0C000100; // jal 0x100

  typedef struct packed {
    logic        we_reg, we_mem, mem_rd, load_enable, j_enable, ra_enable;
    logic        branch_i, branch_it, is_lui, ir;
    logic [3:0]  aluop;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jaddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [78:0] obs [2];
  bit          cmp_en = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       in_ready, out_valid, stall, IR;
    logic [4:0] rs_add, rt_add, rd_add, shamt;
    logic [3:0] aluop;
    logic [15:0] I_data;
    logic [25:0] jump_address;
    logic WE_reg, WE_mem, mem_rd, load_enable, j_enable, ra_enable, branch_i, BRANCH_IT, is_lui;

    decode_ctrl_pipe #(.ALUOP_W(4), .STALL_CYCLES(g + 1), .HAZARD_EN(1), .LINK_REG(31)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
      .rs_add(rs_add), .rt_add(rt_add), .rd_add(rd_add), .shamt(shamt), .aluop(aluop),
      .IR(IR), .I_data(I_data), .jump_address(jump_address),
      .WE_reg(WE_reg), .WE_mem(WE_mem), .mem_rd(mem_rd),
      .load_enable(load_enable), .j_enable(j_enable), .ra_enable(ra_enable),
      .branch_i(branch_i), .BRANCH_IT(BRANCH_IT), .is_lui(is_lui), .stall(stall)
    );

    assign obs[g] = {in_ready, out_valid, stall, WE_reg, WE_mem, mem_rd, load_enable,
                     j_enable, ra_enable, branch_i, BRANCH_IT, is_lui, IR, aluop,
                     rs_add, rt_add, rd_add, shamt, I_data, jump_address};
  end

  // ---------------- reference model ----------------
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    logic [5:0] op;
    op      = i[31:26];
    e       = '0;
    e.rs    = i[25:21];
    e.rt    = i[20:16];
    e.shamt = i[10:6];
    e.imm   = i[15:0];
    e.jaddr = i[25:0];
    if (op == 6'd0 && i[5:0] == 6'd8) begin
      e.load_enable = 1'b1;
    end else if (op == 6'd0) begin
      e.rd = i[15:11]; e.aluop = i[3:0]; e.we_reg = 1'b1;
    end else if (op == 6'd4 || op == 6'd5) begin
      e.branch_it = 1'b1; e.aluop = 4'd2; e.branch_i = i[26];
    end else if (op == 6'd2 || op == 6'd3) begin
      e.load_enable = 1'b1; e.j_enable = 1'b1;
      if (op == 6'd3) begin e.we_reg = 1'b1; e.ra_enable = 1'b1; e.rd = 5'd31; end
    end else if (op == 6'd15) begin
      e.rd = i[20:16]; e.shamt = 5'd16; e.is_lui = 1'b1; e.we_reg = 1'b1;
    end else if (op >= 6'd32) begin
      e.rd = i[20:16]; e.ir = 1'b1;
      e.we_mem = i[29]; e.we_reg = !i[29]; e.mem_rd = !i[29];
    end else begin
      e.rd = i[20:16]; e.ir = 1'b1; e.aluop = op[3:0]; e.we_reg = 1'b1;
    end
    return e;
  endfunction

  // Does instruction i read register r (r == 0 never counts)?
  function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] op;
    bit jr, rs_used, rt_used;
    op      = i[31:26];
    jr      = (op == 6'd0) && (i[5:0] == 6'd8);
    rs_used = !(op == 6'd2 || op == 6'd3 || op == 6'd15);
    rt_used = (op == 6'd0 && !jr) || op == 6'd4 || op == 6'd5 || (op >= 6'd32 && i[29]);
    return (r != 5'd0) && ((rs_used && i[25:21] == r) || (rt_used && i[20:16] == r));
  endfunction

  int       stalls [2] = '{1, 2};
  bit       m_ready_en [2];
  bit       m_valid [2];
  bit       m_stall [2];
  exp_t     m_out [2];
  bit [4:0] m_ld [2];    // destination of the last issued load, 0 = none
  int       m_owed [2];  // bubbles still to issue

  function automatic bit m_hazard(input int k);
    return in_valid && reads_reg(instr, m_ld[k]);
  endfunction

  function automatic bit m_in_ready(input int k);
    return m_ready_en[k] && (flush || ((!m_valid[k] || out_ready) && !m_hazard(k) && m_owed[k] == 0));
  endfunction

  function automatic int m_owed_after(input int k);
    return ((m_owed[k] > 0) ? m_owed[k] : stalls[k]) - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ready_en[k] <= 1'b0; m_valid[k] <= 1'b0; m_stall[k] <= 1'b0;
        m_out[k] <= '0; m_ld[k] <= '0; m_owed[k] <= 0;
      end else begin
        m_ready_en[k] <= 1'b1;
        if (flush) begin
          m_valid[k] <= 1'b0; m_stall[k] <= 1'b0; m_out[k] <= '0;
          m_owed[k] <= 0; m_ld[k] <= '0;
        end else if (!m_valid[k] || out_ready) begin
          if (m_owed[k] > 0 || m_hazard(k)) begin
            m_valid[k] <= 1'b0; m_stall[k] <= 1'b1; m_out[k] <= '0;
            m_owed[k] <= m_owed_after(k);
            if (m_owed_after(k) == 0) m_ld[k] <= '0;
          end else if (in_valid && m_ready_en[k]) begin
            m_valid[k] <= 1'b1; m_stall[k] <= 1'b0; m_out[k] <= ref_decode(instr);
            m_ld[k] <= (instr[31] && !instr[29]) ? instr[20:16] : 5'd0;
          end else begin
            m_valid[k] <= 1'b0; m_stall[k] <= 1'b0; m_out[k] <= '0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Data fields only matter while out_valid; handshake and enables always.
  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [78:0] exp, mask;
        exp  = {m_in_ready(k), m_valid[k], m_stall[k], m_out[k]};
        mask = m_valid[k] ? '1 : {12'hFFF, 67'd0};
        check($sformatf("cycle_inst%0d", k), obs[k] & mask, exp & mask);
      end
    end
  end

  task automatic step(input bit iv, input logic [31:0] ins, input bit fl, input bit ordy);
    @(negedge clk);
    in_valid  = iv;
    instr     = ins;
    flush     = fl;
    out_ready = ordy;
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  op;
    r = $urandom;
    case ($urandom_range(0, 13))
      0, 1:    op = 6'd0;
      2:       begin op = 6'd0; r[5:0] = 6'd8; end
      3:       op = 6'd2;
      4:       op = 6'd3;
      5:       op = 6'd4;
      6:       op = 6'd5;
      7:       op = 6'd15;
      8, 9:    op = 6'h23;
      10:      op = 6'h2B;
      11:      op = 6'd8;
      12:      op = 6'h20;
      default: op = 6'd13;
    endcase
    // Small register numbers make load-use collisions frequent.
    return {op, 2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)), r[15:0]};
  endfunction

  initial begin
    logic [77:0] snap;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_inst0", obs[0], 79'd0);
    check("reset_inst1", obs[1], 79'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    #2;
    check("ready_low_before_edge", 79'(g_dut[0].in_ready), 79'd0);
    step(0, '0, 0, 1);
    check("ready_after_edge", 79'(g_dut[0].in_ready), 79'd1);

    // add $3,$1,$2
    step(1, ADD, 0, 1);
    step(0, '0, 0, 1);
    check("add_fields", 79'({g_dut[0].out_valid, g_dut[0].rd_add, g_dut[0].rt_add, g_dut[0].rs_add,
                             g_dut[0].aluop, g_dut[0].WE_reg, g_dut[0].IR}),
          79'({1'b1, 5'd3, 5'd2, 5'd1, 4'd0, 1'b1, 1'b0}));

    // load-use hazard
    step(1, LW5, 0, 1);
    step(1, ADD2, 0, 1);
    check("lu_ready0", 79'({g_dut[0].in_ready, g_dut[1].in_ready}), 79'd0);
    step(1, ADD2, 0, 1);
    check("lu_bubble0", 79'({g_dut[0].stall, g_dut[0].out_valid, g_dut[0].in_ready}), 79'b101);
    check("lu_bubble1a", 79'({g_dut[1].stall, g_dut[1].out_valid, g_dut[1].in_ready}), 79'b100);
    step(1, ADD2, 0, 1);
    check("lu_issue0", 79'({g_dut[0].out_valid, g_dut[0].stall, g_dut[0].rd_add}), 79'({2'b10, 5'd6}));
    check("lu_bubble1b", 79'({g_dut[1].stall, g_dut[1].out_valid}), 79'b10);
    step(0, '0, 0, 1);
    check("lu_issue1", 79'({g_dut[1].out_valid, g_dut[1].stall, g_dut[1].rd_add}), 79'({2'b10, 5'd6}));

    // no-hazard and store-data hazard cases
    step(1, LW0, 0, 1);
    step(1, ADD00, 0, 1);
    check("lw0_no_hazard", 79'(g_dut[0].in_ready), 79'd1);
    step(1, LW5, 0, 1);
    step(1, SW7, 0, 1);
    check("sw_addr_no_hazard", 79'({g_dut[0].in_ready, g_dut[1].in_ready}), 79'b11);
    step(1, LW5, 0, 1);
    step(1, SW5, 0, 1);
    check("sw_data_hazard", 79'(g_dut[0].in_ready), 79'd0);
    step(1, SW5, 0, 1);
    check("sw_data_bubble", 79'({g_dut[0].stall, g_dut[0].out_valid}), 79'b10);
    repeat (3) step(0, '0, 0, 1);

    // back-pressure
    step(1, ADD, 0, 1);
    step(1, ADDI, 0, 0);
    snap = obs[0][77:0];
    check("bp_ready_low", 79'(g_dut[0].in_ready), 79'd0);
    repeat (2) begin
      step(1, ADDI, 0, 0);
      check("bp_hold", 79'({g_dut[0].in_ready, obs[0][77:0]}), 79'({1'b0, snap}));
    end
    step(1, ADDI, 0, 1);
    check("bp_release", 79'({g_dut[0].in_ready, obs[0][77:0]}), 79'({1'b1, snap}));
    step(0, '0, 0, 1);
    check("bp_next", 79'({g_dut[0].out_valid, g_dut[0].rd_add, g_dut[0].IR, g_dut[0].aluop, g_dut[0].WE_reg}),
          79'({1'b1, 5'd4, 1'b1, 4'd8, 1'b1}));

    // flush during a bubble
    step(1, LW5, 0, 1);
    step(1, ADD2, 0, 1);
    step(1, ADD2, 1, 1);
    check("fl_in_bubble", 79'({g_dut[0].stall, g_dut[1].stall, g_dut[0].in_ready, g_dut[1].in_ready}), 79'b1111);
    step(0, '0, 0, 1);
    check("fl_after0", 79'({g_dut[0].out_valid, g_dut[0].stall, g_dut[0].in_ready}), 79'b001);
    check("fl_after1", 79'({g_dut[1].out_valid, g_dut[1].stall, g_dut[1].in_ready}), 79'b001);
    step(0, '0, 0, 1);
    check("fl_never_issued", 79'({g_dut[0].out_valid, g_dut[1].out_valid}), 79'b00);

    // flush coincident with a hazard
    step(1, LW5, 0, 1);
    step(1, ADD2, 1, 1);
    step(0, '0, 0, 1);
    check("fl_hazard_same", 79'({g_dut[0].stall, g_dut[0].out_valid, g_dut[1].stall, g_dut[1].out_valid}), 79'd0);

    // jal
    step(1, JAL, 0, 1);
    step(0, '0, 0, 1);
    check("jal_fields", 79'({g_dut[0].out_valid, g_dut[0].rd_add, g_dut[0].WE_reg, g_dut[0].ra_enable,
                             g_dut[0].j_enable, g_dut[0].load_enable, g_dut[0].jump_address}),
          79'({1'b1, 5'd31, 4'b1111, 26'h0000100}));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins;
      ins = (in_valid && $urandom_range(0, 1) == 1) ? instr : rand_instr();
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (4) step(0, '0, 0, 1);

    // reset in the middle of a stall
    step(1, LW5, 0, 1);
    step(1, ADD2, 0, 1);
    step(1, ADD2, 0, 1);
    check("pre_reset_stall", 79'({g_dut[0].stall, g_dut[1].stall}), 79'b11);
    #1 rst_n = 1'b0;
    #1;
    check("midstall_reset0", obs[0], 79'd0);
    check("midstall_reset1", obs[1], 79'd0);
    step(0, '0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, '0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
